except_ctrl: RTL
================

// Module: except_ctrl
// PURPOSE
//  Parametrised, registered exception/interrupt controller for the M stage of the MIPS pipeline.
//  Synchronises and latches hardware interrupt lines, then prioritises interrupts and M-stage
//  exception flags, with one event resolved per cycle.
//  Runs a flush/redirect sequence with a ready handshake to fetch, and a one-cycle CP0 commit pulse.
// PARAMETERS
//  N_HW_INT    6             hardware interrupt lines, 1..6, mapped to Cause.IP[2+N_HW_INT-1:2]
//  SYNC_STAGES 2             synchroniser flops per ext_int line, >=1
//  EXC_VEC     32'hBFC00380  common exception entry PC
//  FLUSH_CYC   1             cycles flush_all stays high after commit, >=1
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous, active-high reset
//  ext_int        in   N_HW_INT  async hardware interrupt request lines
//  stallM         in   1         M stage stalled; no event may be taken
//  pcM            in   32        PC of M-stage instruction
//  data_addrM     in   32        load/store address of M-stage instruction
//  in_dslotM      in   1         M-stage instruction is in a branch delay slot
//  flagsM         in   8         {eret,adES,adEL_data,brk,sys,ov,ri,adEL_pc}
//  cp0_status     in   32        Status (IE=bit0, EXL=bit1, IM=bits15:8)
//  cp0_cause      in   32        Cause (software IP = bits9:8)
//  cp0_epc        in   32        EPC, target of ERET
//  redirect_ready in   1         fetch accepted redirect_pc
//  commit         out  1         one-cycle pulse: CP0 writes exc_code/epc/bd/badvaddr
//  exc_code       out  5         Cause.ExcCode of committed event
//  epc_out        out  32        EPC value to write
//  bd_out         out  1         Cause.BD to write
//  badvaddr_out   out  32        BadVAddr to write; valid when exc_code is 4 or 5
//  is_eret        out  1         committed event is ERET (CP0 clears EXL, no EPC write)
//  hw_ip          out  N_HW_INT  synchronised pending HW lines, for Cause.IP
//  flush_all      out  1         flush IF..M and block WB of the faulting instruction
//  redirect_valid out  1         redirect_pc is valid; held until redirect_ready
//  redirect_pc    out  32        EXC_VEC, or cp0_epc for ERET
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, synchronisers and timer cleared.
//  - int_req = IE & ~EXL & |({hw_ip,cause[9:8]} & IM[2+N_HW_INT-1:0]).
//  - Priority, highest first, with ExcCode:
//    int 0x00 > adEL_pc 0x04 > ri 0x0a > ov 0x0c > sys 0x08 > brk 0x09 > adEL_data 0x04 > adES 0x05 > eret.
//  - epc_out = in_dslotM ? pcM-4 : pcM (mod 2^32). badvaddr_out = pcM for adEL_pc, else data_addrM.
//  - FSM IDLE: event & ~stallM -> COMMIT, capturing all outputs. Event under stallM waits, no capture.
//  - COMMIT (1 cycle): commit=1, flush_all=1, redirect_valid=1 -> FLUSH.
//  - FLUSH: flush_all held for FLUSH_CYC cycles total. redirect_valid is held until redirect_ready.
//    Both conditions done -> IDLE. Captured outputs are stable throughout.
//  - New events are ignored outside IDLE, since the flush kills them.
//  - ready in the same cycle as COMMIT completes the handshake; the earliest return to IDLE is cycle 2.
//  - Interrupt latency from ext_int edge to int_req is SYNC_STAGES cycles.
//  - hw_ip is level-following and never latched.
//  - rst mid-sequence returns to IDLE next edge and drops flush_all/redirect_valid.
// CONFIGURATION
//  EXCEPT_TIMER_INT_EN defined:
//    internal 32-bit count (+1 every 2nd clk) and compare register (write port cmp_we/cmp_wdata).
//    count==compare sets a timer pending bit, ORed into the top HW line; a compare write clears it.
//  Not defined: no timer logic or ports; top HW line is ext_int only.
// STRUCTURE
//  Shared package exc_pkg: ExcCode constants, flagsM bit indices, FSM state encoding,
//    Status/Cause field positions.
//  One sub-module int_sync: SYNC_STAGES-deep synchroniser per line (generate loop).
// TESTING
//  1. flagsM=8'h04 (ov), pcM=32'h80001000, in_dslotM=0:
//     commit 1 cycle later, exc_code=0x0c, epc_out=32'h80001000, redirect_pc=32'hBFC00380.
//  2. sys with in_dslotM=1, pcM=32'h80002004: epc_out=32'h80002000, bd_out=1.
//  3. ext_int[0]=1, IE=1, EXL=0, IM[2]=1, with ri flag also set:
//     exc_code=0x00 after SYNC_STAGES cycles; with EXL=1 ri wins instead (0x0a).
//  4. adES with stallM=1 for 3 cycles: no commit; commit 1 cycle after stallM falls.
//  5. eret, cp0_epc=32'h80003000, redirect_ready low 4 cycles:
//     redirect_valid held, redirect_pc=32'h80003000, is_eret=1.
//  6. rst asserted during FLUSH: next cycle flush_all=0, redirect_valid=0, FSM IDLE.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the M-stage exception controller: ExcCode values,
// flagsM bit positions, CP0 Status/Cause field positions, FSM encoding and
// the fixed-priority event selector.
package exc_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdEL = 5'h04;
  localparam logic [4:0] ExcAdES = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0a;
  localparam logic [4:0] ExcOv   = 5'h0c;

  // flagsM = {eret, adES, adEL_data, brk, sys, ov, ri, adEL_pc}
  localparam int unsigned FlagAdelPc   = 0;
  localparam int unsigned FlagRi       = 1;
  localparam int unsigned FlagOv       = 2;
  localparam int unsigned FlagSys      = 3;
  localparam int unsigned FlagBrk      = 4;
  localparam int unsigned FlagAdelData = 5;
  localparam int unsigned FlagAdes     = 6;
  localparam int unsigned FlagEret     = 7;

  // CP0 field positions
  localparam int unsigned StatusIe   = 0;
  localparam int unsigned StatusExl  = 1;
  localparam int unsigned StatusImLo = 8;
  localparam int unsigned CauseIpLo  = 8;

  typedef enum logic [1:0] {StIdle, StCommit, StFlush} exc_state_e;

  typedef struct packed {
    logic [4:0] code;
    logic       eret;
    logic       pc_fault;  // BadVAddr comes from the PC rather than the data address
  } exc_sel_t;

  // Highest-priority event first; eret only wins when nothing else is pending.
  function automatic exc_sel_t exc_select(input logic int_req, input logic [7:0] flags);
    exc_sel_t s;
    s = '{code: ExcInt, eret: 1'b0, pc_fault: 1'b0};
    if (int_req) begin
      s.code = ExcInt;
    end else if (flags[FlagAdelPc]) begin
      s.code     = ExcAdEL;
      s.pc_fault = 1'b1;
    end else if (flags[FlagRi]) begin
      s.code = ExcRi;
    end else if (flags[FlagOv]) begin
      s.code = ExcOv;
    end else if (flags[FlagSys]) begin
      s.code = ExcSys;
    end else if (flags[FlagBrk]) begin
      s.code = ExcBp;
    end else if (flags[FlagAdelData]) begin
      s.code = ExcAdEL;
    end else if (flags[FlagAdes]) begin
      s.code = ExcAdES;
    end else if (flags[FlagEret]) begin
      s.eret = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Per-line multi-flop synchroniser for asynchronous interrupt request lines.
module int_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  for (genvar g = 0; g < Width; g++) begin : g_line
    logic [Stages-1:0] sync_q;

    if (Stages == 1) begin : g_one
      // Single flop: sample the raw line
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= d[g];
      end
    end else begin : g_many
      // Shift chain: raw line enters at bit 0, synchronised value leaves at the top
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[Stages-2:0], d[g]};
      end
    end

    assign q[g] = sync_q[Stages-1];
  end

endmodule

// File: rtl/except_ctrl.sv
// M-stage exception/interrupt controller. Resolves one interrupt or exception
// per cycle, captures the CP0 update values, pulses commit, then holds a flush
// and a redirect handshake to fetch until both are done.
// Optional feature macro: EXCEPT_TIMER_INT_EN adds an internal count/compare
// timer whose pending bit is ORed into the top hardware interrupt line.
module except_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned N_HW_INT    = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VEC     = 32'hBFC00380,
  parameter int unsigned FLUSH_CYC   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic                stallM,
  input  logic [31:0]         pcM,
  input  logic [31:0]         data_addrM,
  input  logic                in_dslotM,
  input  logic [7:0]          flagsM,
  input  logic [31:0]         cp0_status,
  input  logic [31:0]         cp0_cause,
  input  logic [31:0]         cp0_epc,
  input  logic                redirect_ready,
`ifdef EXCEPT_TIMER_INT_EN
  input  logic                cmp_we,
  input  logic [31:0]         cmp_wdata,
`endif
  output logic                commit,
  output logic [4:0]          exc_code,
  output logic [31:0]         epc_out,
  output logic                bd_out,
  output logic [31:0]         badvaddr_out,
  output logic                is_eret,
  output logic [N_HW_INT-1:0] hw_ip,
  output logic                flush_all,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_CYC);
  localparam logic [FlushW-1:0] FlushOne  = FlushW'(1);

  logic [N_HW_INT-1:0] ext_sync;
  logic [N_HW_INT+1:0] ip_all;
  logic [N_HW_INT+1:0] im;
  logic                int_req;
  logic                evt_any;
  logic                take;
  exc_sel_t            sel;

  exc_state_e          state_q, state_d;
  logic [FlushW-1:0]   flush_left_q;
  logic                rdy_done_q;
  logic                flush_last;

  int_sync #(
    .Width (N_HW_INT),
    .Stages(SYNC_STAGES)
  ) u_int_sync (
    .clk(clk),
    .rst(rst),
    .d  (ext_int),
    .q  (ext_sync)
  );

`ifdef EXCEPT_TIMER_INT_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        half_q;
  logic        timer_pend_q;

  // Count advances every second clock; a compare write always clears the pending bit
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      compare_q    <= '0;
      half_q       <= 1'b0;
      timer_pend_q <= 1'b0;
    end else begin
      half_q <= ~half_q;
      if (half_q) count_q <= count_q + 32'd1;
      if (cmp_we) begin
        compare_q    <= cmp_wdata;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  // Timer shares the top hardware line with ext_int
  always_comb begin
    hw_ip               = ext_sync;
    hw_ip[N_HW_INT-1]   = ext_sync[N_HW_INT-1] | timer_pend_q;
  end
`else
  assign hw_ip = ext_sync;
`endif

  // {hw lines, software IP1:IP0} masked by IM, gated by IE and EXL
  assign ip_all  = {hw_ip, cp0_cause[CauseIpLo +: 2]};
  assign im      = cp0_status[StatusImLo +: N_HW_INT + 2];
  assign int_req = cp0_status[StatusIe] & ~cp0_status[StatusExl] & (|(ip_all & im));

  assign sel     = exc_select(int_req, flagsM);
  assign evt_any = int_req | (|flagsM);
  assign take    = (state_q == StIdle) & evt_any & ~stallM;

  assign flush_last = (flush_left_q <= FlushOne);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: one commit cycle, then flush until both flush timer and handshake finish
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (evt_any && !stallM) state_d = StCommit;
      StCommit: state_d = StFlush;
      StFlush:  if (flush_last && (rdy_done_q || redirect_ready)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Flush timer and redirect handshake tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_left_q <= '0;
      rdy_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StCommit: begin
          flush_left_q <= FlushInit;
          rdy_done_q   <= redirect_ready;
        end
        StFlush: begin
          if (flush_left_q != '0) flush_left_q <= flush_left_q - FlushOne;
          if (redirect_ready)     rdy_done_q   <= 1'b1;
        end
        default: begin
          flush_left_q <= '0;
          rdy_done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Control outputs decoded from state
  always_comb begin
    commit         = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      StCommit: begin
        commit         = 1'b1;
        flush_all      = 1'b1;
        redirect_valid = 1'b1;
      end
      StFlush: begin
        flush_all      = (flush_left_q != '0);
        redirect_valid = ~rdy_done_q;
      end
      default: ;
    endcase
  end

  // Capture the CP0 update values when an event is taken; held until the next event
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_code     <= '0;
      epc_out      <= '0;
      bd_out       <= 1'b0;
      badvaddr_out <= '0;
      is_eret      <= 1'b0;
      redirect_pc  <= '0;
    end else if (take) begin
      exc_code     <= sel.code;
      epc_out      <= in_dslotM ? (pcM - 32'd4) : pcM;
      bd_out       <= in_dslotM;
      badvaddr_out <= sel.pc_fault ? pcM : data_addrM;
      is_eret      <= sel.eret;
      redirect_pc  <= sel.eret ? cp0_epc : EXC_VEC;
    end
  end

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status[31:StatusImLo+N_HW_INT+2], cp0_status[StatusImLo-1:2],
                             cp0_cause[31:CauseIpLo+2], cp0_cause[CauseIpLo-1:0]};

endmodule
